data_sync: RTL

DATA_SYNC -- requirements
Module: data_sync

---
 rtl/data_sync_if.sv | 26 ++
 rtl/data_sync.sv | 87 ++++++++
 2 files changed

// File: rtl/data_sync_if.sv
// Bus bundle between a source/consumer (master) and the data_sync capture block (slave).
// Handshake: sync_valid high means sync_bus holds an unconsumed word; a word is consumed on
// any rising clk edge where sync_valid && sync_ack; sync_ack while sync_valid is low is ignored.
interface data_sync_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic                 sync_ack;
  logic                 overrun_clr;
  logic [BUS_WIDTH-1:0] sync_bus;
  logic                 enable_pulse;
  logic                 sync_valid;
  logic                 overrun;
  logic [7:0]           overrun_cnt;

  modport master (
    output unsync_bus, bus_enable, sync_ack, overrun_clr,
    input  sync_bus, enable_pulse, sync_valid, overrun, overrun_cnt
  );

  modport slave (
    input  unsync_bus, bus_enable, sync_ack, overrun_clr,
    output sync_bus, enable_pulse, sync_valid, overrun, overrun_cnt
  );
endinterface

// File: rtl/data_sync.sv
// Enable-qualified bus synchronizer: the level enable crosses through a flop chain, and its
// rising edge captures the (stable) source bus into a held word with valid/ack and overrun tracking.
module data_sync #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  data_sync_if.slave   bus_if
);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("data_sync: NUM_STAGES must be at least 2");
  end

  logic [NUM_STAGES-1:0] sync_q, sync_d;
  logic                  en_dly_q, en_dly_d;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic                  pulse_q, pulse_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic [7:0]            ovr_cnt_q, ovr_cnt_d;

  logic en_sync;
  logic cap;
  logic ovr_evt;

  assign en_sync = sync_q[NUM_STAGES-1];
  assign cap     = en_sync & ~en_dly_q;
  // An overwrite only counts when the held word is neither empty nor consumed this cycle.
  assign ovr_evt = cap & valid_q & ~bus_if.sync_ack;

  always_comb begin
    sync_d    = {sync_q[NUM_STAGES-2:0], bus_if.bus_enable};
    en_dly_d  = en_sync;
    data_d    = data_q;
    pulse_d   = cap;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;

    if (cap) begin
      data_d  = bus_if.unsync_bus;
      valid_d = 1'b1;
    end else if (bus_if.sync_ack) begin
      valid_d = 1'b0;
    end

    // A clear coinciding with a new overrun keeps that event: flag set, count of one.
    if (bus_if.overrun_clr) begin
      ovr_d     = ovr_evt;
      ovr_cnt_d = ovr_evt ? 8'd1 : 8'd0;
    end else if (ovr_evt) begin
      ovr_d = 1'b1;
      if (ovr_cnt_q != 8'hFF) begin
        ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      en_dly_q  <= 1'b0;
      data_q    <= '0;
      pulse_q   <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= 8'd0;
    end else begin
      sync_q    <= sync_d;
      en_dly_q  <= en_dly_d;
      data_q    <= data_d;
      pulse_q   <= pulse_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign bus_if.sync_bus     = data_q;
  assign bus_if.enable_pulse = pulse_q;
  assign bus_if.sync_valid   = valid_q;
  assign bus_if.overrun      = ovr_q;
  assign bus_if.overrun_cnt  = ovr_cnt_q;

endmodule
